// File: rtl/comp_pkg.sv
// Shared types, state encoding and default sizing for the compressor history window.
package comp_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RUN,
      DRAIN,
      DONE
   } comp_win_state_e;

   localparam int unsigned DEF_HIST_DEPTH = 8192;
   localparam int unsigned DEF_IN_BYTES   = 16;
   localparam int unsigned DEF_CMP_BYTES  = 16;
   localparam int unsigned DEF_MAX_DIST   = 4095;
   localparam int unsigned DEF_DIST_W     = 12;

   // Address width of the circular history for a power-of-two depth.
   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/comp_hist_ram.sv
// Circular byte history: one masked beat-wide write port, two unaligned
// combinational read windows (lookahead and match candidate).
module comp_hist_ram
   import comp_pkg::*;
#(
   parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH,
   parameter int unsigned IN_BYTES   = DEF_IN_BYTES,
   parameter int unsigned CMP_BYTES  = DEF_CMP_BYTES
) (
   input  logic                          clock,
   input  logic [$clog2(HIST_DEPTH)-1:0] wr_addr,
   input  logic [IN_BYTES-1:0]           wr_mask,
   input  logic [IN_BYTES*8-1:0]         wr_data,
   input  logic [$clog2(HIST_DEPTH)-1:0] la_addr,
   output logic [CMP_BYTES*8-1:0]        la_data,
   input  logic [$clog2(HIST_DEPTH)-1:0] mt_addr,
   output logic [CMP_BYTES*8-1:0]        mt_data
);

   localparam int unsigned IDX_W = idx_width(HIST_DEPTH);

   byte_t hist_q [HIST_DEPTH];

   // Byte-masked write of one input beat; addresses wrap at the end of the store.
   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < IN_BYTES; i++) begin
         if (wr_mask[i]) begin
            hist_q[wr_addr + IDX_W'(i)] <= wr_data[i*8 +: 8];
         end
      end
   end

   // Unaligned wrapping reads of CMP_BYTES consecutive bytes for both windows.
   always_comb begin
      la_data = '0;
      mt_data = '0;
      for (int unsigned i = 0; i < CMP_BYTES; i++) begin
         la_data[i*8 +: 8] = hist_q[la_addr + IDX_W'(i)];
         mt_data[i*8 +: 8] = hist_q[mt_addr + IDX_W'(i)];
      end
   end

endmodule

// File: rtl/comp_history_window.sv
// Compressor input stage: buffers the byte stream in a circular history and
// presents lookahead, hash key and LZ match-candidate windows to the core.
module comp_history_window
   import comp_pkg::*;
#(
   parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH,
   parameter int unsigned IN_BYTES   = DEF_IN_BYTES,
   parameter int unsigned CMP_BYTES  = DEF_CMP_BYTES,
   parameter int unsigned MAX_DIST   = DEF_MAX_DIST,
   parameter int unsigned DIST_W     = DEF_DIST_W
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           restart,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [IN_BYTES*8-1:0]          in_data,
   input  logic [$clog2(IN_BYTES):0]      in_nbytes,
   input  logic                           in_last,
   input  logic [DIST_W-1:0]              match_dist,
   input  logic                           adv_valid,
   input  logic [$clog2(CMP_BYTES):0]     adv_len,
   output logic                           cur_valid,
   output logic [CMP_BYTES*8-1:0]         cur_bytes,
   output logic [CMP_BYTES-1:0]           cur_mask,
   output logic                           cmp_valid,
   output logic [CMP_BYTES*8-1:0]         cmp_bytes,
   output logic                           hash_valid,
   output logic [23:0]                    hash_key,
   output logic [31:0]                    byte_ptr,
   output logic                           done
);

   localparam int unsigned IDX_W     = idx_width(HIST_DEPTH);
   localparam logic [31:0] WIN_LIMIT = 32'(HIST_DEPTH - MAX_DIST);

   comp_win_state_e state_q, state_d;
   logic [31:0]     wr_ptr_q, wr_ptr_d;
   logic [31:0]     rd_ptr_q, rd_ptr_d;

   logic [31:0]          avail;
   logic [31:0]          avail_d;
   logic                 in_fire;
   logic [31:0]          in_len;
   logic [IN_BYTES-1:0]  wr_mask;
   logic                 adv_fire;
   logic [31:0]          adv_amt;
   logic [IDX_W-1:0]     mt_addr;
   logic [CMP_BYTES*8-1:0] la_data;
   logic [CMP_BYTES*8-1:0] mt_data;

   comp_hist_ram #(
      .HIST_DEPTH (HIST_DEPTH),
      .IN_BYTES   (IN_BYTES),
      .CMP_BYTES  (CMP_BYTES)
   ) u_hist (
      .clock   (clock),
      .wr_addr (wr_ptr_q[IDX_W-1:0]),
      .wr_mask (wr_mask),
      .wr_data (in_data),
      .la_addr (rd_ptr_q[IDX_W-1:0]),
      .la_data (la_data),
      .mt_addr (mt_addr),
      .mt_data (mt_data)
   );

   // Flow control, beat acceptance and clamped consume length.
   always_comb begin
      avail    = wr_ptr_q - rd_ptr_q;
      in_ready = ((state_q == IDLE) || (state_q == FILL) || (state_q == RUN)) &&
                 ((avail + 32'(IN_BYTES)) <= WIN_LIMIT);
      in_fire  = in_valid && in_ready;
      in_len   = (in_nbytes == '0) ? 32'd1 : 32'(in_nbytes);
      wr_mask  = '0;
      for (int unsigned i = 0; i < IN_BYTES; i++) begin
         wr_mask[i] = in_fire && (i < in_len);
      end
      cur_valid = (avail >= 32'(CMP_BYTES)) || ((state_q == DRAIN) && (avail != '0));
      adv_fire  = adv_valid && cur_valid;
      adv_amt   = (adv_len == '0) ? 32'd1 : 32'(adv_len);
      if (adv_amt > avail) begin
         adv_amt = avail;
      end
      if (adv_amt > 32'(CMP_BYTES)) begin
         adv_amt = 32'(CMP_BYTES);
      end
   end

   // Next pointers and stream FSM; transitions look at avail after this cycle's update.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q + (in_fire ? in_len : 32'd0);
      rd_ptr_d = rd_ptr_q + (adv_fire ? adv_amt : 32'd0);
      avail_d  = wr_ptr_d - rd_ptr_d;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               state_d = in_last ? DRAIN : FILL;
            end
         end
         FILL: begin
            if (in_fire && in_last) begin
               state_d = DRAIN;
            end else if (avail_d >= 32'(CMP_BYTES)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (in_fire && in_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (avail_d == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (restart) begin
               state_d  = IDLE;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and pointer registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Lookahead, hash and match windows; bytes closer than match_dist replicate from the lookahead.
   always_comb begin
      mt_addr   = rd_ptr_q[IDX_W-1:0] - IDX_W'(match_dist);
      cur_mask  = '0;
      cur_bytes = '0;
      cmp_bytes = '0;
      for (int unsigned i = 0; i < CMP_BYTES; i++) begin
         cur_mask[i] = (i < avail);
         if (cur_mask[i]) begin
            cur_bytes[i*8 +: 8] = la_data[i*8 +: 8];
         end
      end
      hash_valid = (avail >= 32'd3);
      hash_key   = hash_valid ? {la_data[7:0], la_data[15:8], la_data[23:16]} : '0;
      cmp_valid  = cur_valid && (match_dist != '0) &&
                   (32'(match_dist) <= MAX_DIST) && (32'(match_dist) <= rd_ptr_q);
      if (cmp_valid) begin
         for (int unsigned i = 0; i < CMP_BYTES; i++) begin
            if (i < 32'(match_dist)) begin
               cmp_bytes[i*8 +: 8] = mt_data[i*8 +: 8];
            end else begin
               cmp_bytes[i*8 +: 8] = cur_bytes[(i - 32'(match_dist))*8 +: 8];
            end
         end
      end
      byte_ptr = rd_ptr_q;
      done     = (state_q == DONE);
   end

   // A short beat is only legal as the final beat of the stream.
   a_partial_needs_last: assert property (
      @(posedge clock) disable iff (reset)
      (in_valid && in_ready && !in_last) |-> (32'(in_nbytes) == 32'(IN_BYTES)));

endmodule

// File: tb/tb_comp_history_window.sv
// Scoreboard bench for comp_history_window: stimulus queues expected output
// values, a negedge monitor pops and compares them against the DUT.
module tb_comp_history_window;

   logic         clock = 1'b0;
   logic         reset;
   logic         restart;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [4:0]   in_nbytes;
   logic         in_last;
   logic [11:0]  match_dist;
   logic         adv_valid;
   logic [4:0]   adv_len;
   logic         cur_valid;
   logic [127:0] cur_bytes;
   logic [15:0]  cur_mask;
   logic         cmp_valid;
   logic [127:0] cmp_bytes;
   logic         hash_valid;
   logic [23:0]  hash_key;
   logic [31:0]  byte_ptr;
   logic         done;

   comp_history_window #(
      .HIST_DEPTH (8192),
      .IN_BYTES   (16),
      .CMP_BYTES  (16),
      .MAX_DIST   (4095),
      .DIST_W     (12)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .restart    (restart),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_nbytes  (in_nbytes),
      .in_last    (in_last),
      .match_dist (match_dist),
      .adv_valid  (adv_valid),
      .adv_len    (adv_len),
      .cur_valid  (cur_valid),
      .cur_bytes  (cur_bytes),
      .cur_mask   (cur_mask),
      .cmp_valid  (cmp_valid),
      .cmp_bytes  (cmp_bytes),
      .hash_valid (hash_valid),
      .hash_key   (hash_key),
      .byte_ptr   (byte_ptr),
      .done       (done)
   );

   always #5 clock = ~clock;

   typedef enum int {F_READY, F_CURV, F_CURB, F_MASK, F_CMPV, F_CMPB,
                     F_HASHV, F_HASH, F_PTR, F_DONE} fld_e;

   typedef struct {
      string        name;
      fld_e         f;
      logic [127:0] exp;
   } exp_t;

   exp_t sb[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   function automatic logic [127:0] actual(fld_e f);
      case (f)
         F_READY: return 128'(in_ready);
         F_CURV:  return 128'(cur_valid);
         F_CURB:  return cur_bytes;
         F_MASK:  return 128'(cur_mask);
         F_CMPV:  return 128'(cmp_valid);
         F_CMPB:  return cmp_bytes;
         F_HASHV: return 128'(hash_valid);
         F_HASH:  return 128'(hash_key);
         F_PTR:   return 128'(byte_ptr);
         default: return 128'(done);
      endcase
   endfunction

   // Monitor: every expectation queued before this negedge is compared now.
   always @(negedge clock) begin : monitor
      exp_t         e;
      logic [127:0] act;
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         act = actual(e.f);
         n_checks++;
         if (act === e.exp) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
         end
      end
   end

   task automatic chk(input string n, input fld_e f, input logic [127:0] v);
      exp_t e;
      e.name = n;
      e.f    = f;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic beat(input logic [127:0] d, input int unsigned nb, input logic last);
      in_valid  = 1'b1;
      in_data   = d;
      in_nbytes = 5'(nb);
      in_last   = last;
      tick();
      in_valid  = 1'b0;
      in_last   = 1'b0;
   endtask

   task automatic adv(input int unsigned len);
      adv_valid = 1'b1;
      adv_len   = 5'(len);
      tick();
      adv_valid = 1'b0;
   endtask

   // Beat whose byte i holds the low 8 bits of (base + i).
   function automatic logic [127:0] seq_beat(input int unsigned base);
      logic [127:0] d;
      for (int unsigned i = 0; i < 16; i++) begin
         d[i*8 +: 8] = 8'(base + i);
      end
      return d;
   endfunction

   initial begin : timeout
      #200000;
      $display("FAIL timeout: got no finish expected finish by 200000");
      $fatal(1);
   end

   initial begin : stim
      reset      = 1'b1;
      restart    = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_nbytes  = 5'd16;
      in_last    = 1'b0;
      match_dist = '0;
      adv_valid  = 1'b0;
      adv_len    = '0;

      // Reset state
      chk("rst_ready", F_READY, 128'd1);
      chk("rst_curv",  F_CURV,  128'd0);
      chk("rst_curb",  F_CURB,  128'd0);
      chk("rst_mask",  F_MASK,  128'd0);
      chk("rst_cmpv",  F_CMPV,  128'd0);
      chk("rst_hashv", F_HASHV, 128'd0);
      chk("rst_hash",  F_HASH,  128'd0);
      chk("rst_ptr",   F_PTR,   128'd0);
      chk("rst_done",  F_DONE,  128'd0);
      tick();
      reset = 1'b0;

      // Two full beats 0x01..0x20
      beat(seq_beat(1), 16, 1'b0);
      beat(seq_beat(17), 16, 1'b0);
      chk("a_ready", F_READY, 128'd1);
      chk("a_curv",  F_CURV,  128'd1);
      chk("a_curb",  F_CURB,  128'h100f0e0d0c0b0a090807060504030201);
      chk("a_mask",  F_MASK,  128'hffff);
      chk("a_hash",  F_HASH,  128'h010203);
      chk("a_ptr",   F_PTR,   128'd0);
      chk("a_cmpv_d0", F_CMPV, 128'd0);
      tick();
      match_dist = 12'd1;
      chk("a_cmpv_gt_ptr", F_CMPV, 128'd0);
      chk("a_cmpb_gt_ptr", F_CMPB, 128'd0);
      tick();

      // Consume 4, then match at distance 4 and 3
      adv(4);
      match_dist = 12'd4;
      chk("b_ptr",  F_PTR,  128'd4);
      chk("b_curb", F_CURB, 128'h14131211100f0e0d0c0b0a0908070605);
      chk("b_hash", F_HASH, 128'h050607);
      chk("b_cmpv", F_CMPV, 128'd1);
      chk("b_cmpb_d4", F_CMPB, 128'h100f0e0d0c0b0a090807060504030201);
      tick();
      match_dist = 12'd3;
      chk("b_cmpb_d3", F_CMPB, 128'h11100f0e0d0c0b0a0908070605040302);
      tick();
      match_dist = 12'd5;
      chk("b_cmpv_d5", F_CMPV, 128'd0);
      chk("b_cmpb_d5", F_CMPB, 128'd0);
      tick();
      match_dist = 12'd0;
      adv(0);
      chk("b_ptr_len0",  F_PTR,  128'd5);
      chk("b_hash_len0", F_HASH, 128'h060708);
      tick();

      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Back-pressure: 256 beats fill the window to 4096 bytes
      for (int unsigned k = 0; k < 256; k++) begin
         beat(seq_beat(k * 16), 16, 1'b0);
      end
      chk("bp_ready", F_READY, 128'd0);
      chk("bp_ptr",   F_PTR,   128'd0);
      chk("bp_curb",  F_CURB,  128'h0f0e0d0c0b0a09080706050403020100);
      tick();
      in_valid = 1'b1;
      in_data  = {16{8'hee}};
      tick();
      tick();
      chk("bp_stall_ready", F_READY, 128'd0);
      in_valid = 1'b0;
      tick();
      adv(16);
      chk("bp_ready_again", F_READY, 128'd1);
      chk("bp_ptr16",       F_PTR,   128'd16);
      chk("bp_curb16",      F_CURB,  128'h1f1e1d1c1b1a19181716151413121110);
      tick();

      // Final partial beat, drain to the tail
      beat(128'ha5a4a3a2a1, 5, 1'b1);
      chk("dr_ready", F_READY, 128'd0);
      chk("dr_curv",  F_CURV,  128'd1);
      tick();
      for (int unsigned k = 0; k < 255; k++) begin
         adv(16);
      end
      chk("tail_ptr",   F_PTR,   128'd4096);
      chk("tail_curv",  F_CURV,  128'd1);
      chk("tail_mask",  F_MASK,  128'h001f);
      chk("tail_curb",  F_CURB,  128'ha5a4a3a2a1);
      chk("tail_hash",  F_HASH,  128'ha1a2a3);
      chk("tail_done",  F_DONE,  128'd0);
      tick();
      match_dist = 12'd4095;
      chk("tail_cmpv_max", F_CMPV, 128'd1);
      chk("tail_cmpb_max", F_CMPB, 128'h100f0e0d0c0b0a090807060504030201);
      tick();
      match_dist = 12'd4;
      chk("tail_cmpb_d4", F_CMPB, 128'ha5a4a3a2a1fffefdfc);
      tick();
      match_dist = 12'd0;
      adv(16);
      chk("done_flag",  F_DONE,  128'd1);
      chk("done_ready", F_READY, 128'd0);
      chk("done_ptr",   F_PTR,   128'd4101);
      chk("done_curv",  F_CURV,  128'd0);
      chk("done_hashv", F_HASHV, 128'd0);
      tick();
      adv(16);
      chk("done_adv_ignored", F_PTR, 128'd4101);
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rs_ptr",   F_PTR,   128'd0);
      chk("rs_ready", F_READY, 128'd1);
      chk("rs_done",  F_DONE,  128'd0);
      tick();

      // Overlap: "AB" repeated
      beat({8{16'h4241}}, 16, 1'b0);
      beat({8{16'h4241}}, 16, 1'b0);
      adv(2);
      match_dist = 12'd2;
      chk("ov_ptr",    F_PTR,  128'd2);
      chk("ov_cmpv",   F_CMPV, 128'd1);
      chk("ov_cmpb_2", F_CMPB, {8{16'h4241}});
      tick();
      match_dist = 12'd1;
      chk("ov_cmpb_1", F_CMPB, {8{16'h4142}});
      tick();
      match_dist = 12'd0;
      chk("ov_cmpv_0", F_CMPV, 128'd0);
      chk("ov_cmpb_0", F_CMPB, 128'd0);
      tick();
      match_dist = 12'd3;
      chk("ov_cmpv_3", F_CMPV, 128'd0);
      chk("ov_cmpb_3", F_CMPB, 128'd0);
      tick();
      match_dist = 12'd0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("run_restart_ptr",  F_PTR,  128'd2);
      chk("run_restart_curv", F_CURV, 128'd1);
      tick();

      // Asynchronous reset mid-RUN with a consume pending
      adv_valid = 1'b1;
      adv_len   = 5'd4;
      #2;
      reset = 1'b1;
      chk("ar_ready", F_READY, 128'd1);
      chk("ar_curv",  F_CURV,  128'd0);
      chk("ar_curb",  F_CURB,  128'd0);
      chk("ar_hashv", F_HASHV, 128'd0);
      chk("ar_ptr",   F_PTR,   128'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk("ar_post_ptr",  F_PTR,  128'd0);
      chk("ar_post_curv", F_CURV, 128'd0);
      tick();
      adv_valid = 1'b0;
      tick();
      tick();

      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/comp_history_window.md
Name: comp_history_window

Overview:
- Parametrised successor to the compressor input stage. Buffers the uncompressed byte stream in a power-of-two circular history.
- Presents to the match/hash logic:
  - the current lookahead bytes;
  - the 3-byte hash key;
  - the candidate match bytes at a backward distance, with LZ overlap semantics.
- Adds over the previous generation: valid/ready input flow control, partial final beat, explicit consume handshake, drain/done state machine, restart.

Parameters:
- HIST_DEPTH, 8192: history bytes; power of two; must be ≥ 2*MAX_DIST.
- IN_BYTES, 16: bytes per input beat.
- CMP_BYTES, 16: lookahead/compare window bytes.
- MAX_DIST, 4095: largest legal backward match distance.
- DIST_W, 12: width of match_dist; 2^DIST_W > MAX_DIST.

Ports:
- clock, in, 1: single clock.
- reset, in, 1: asynchronous, active-high.
- restart, in, 1: one-cycle pulse; DONE→IDLE.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block can accept a beat.
- in_data, in, IN_BYTES*8: byte 0 first in stream order.
- in_nbytes, in, $clog2(IN_BYTES)+1: valid bytes in beat, 1..IN_BYTES.
- in_last, in, 1: final beat of stream.
- match_dist, in, DIST_W: backward distance of candidate match.
- adv_valid, in, 1: core consumes bytes this cycle.
- adv_len, in, $clog2(CMP_BYTES)+1: bytes consumed.
- cur_valid, out, 1: lookahead window valid.
- cur_bytes, out, CMP_BYTES*8: bytes at rd_ptr.
- cur_mask, out, CMP_BYTES: per-byte valid for cur_bytes.
- cmp_valid, out, 1: match_dist legal.
- cmp_bytes, out, CMP_BYTES*8: bytes at rd_ptr-match_dist.
- hash_valid, out, 1: ≥3 bytes available.
- hash_key, out, 24: {byte[rd], byte[rd+1], byte[rd+2]}.
- byte_ptr, out, 32: absolute read pointer rd_ptr.
- done, out, 1: stream fully consumed.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are 32-bit absolute byte counters, modulo 2^32.
  - History index is ptr[$clog2(HIST_DEPTH)-1:0].
  - avail = wr_ptr - rd_ptr (modulo subtract).
- Reset (async): state=IDLE, wr_ptr=rd_ptr=0, history contents don't-care. All outputs 0 except in_ready=1.
- in_ready = 1 when state ∈ {IDLE, FILL, RUN} and avail + IN_BYTES ≤ HIST_DEPTH - MAX_DIST. This guarantees history back to rd_ptr-MAX_DIST is never overwritten.
- Beat acceptance on in_valid&&in_ready:
  - write in_nbytes bytes at wr_ptr;
  - wr_ptr += in_nbytes;
  - in_nbytes=0 is treated as 1;
  - in_nbytes<IN_BYTES is legal only with in_last, otherwise behaviour is undefined (assertion).
- Lookahead and hash:
  - cur_mask[i] = (i < avail).
  - cur_valid = avail≥CMP_BYTES, or (state==DRAIN && avail>0).
  - cur_bytes[i] = byte[rd+i] if cur_mask[i], else 0.
  - hash_valid = avail≥3; hash_key=0 when low.
- Match compare (combinational from registered pointers and match_dist):
  - cmp_valid = cur_valid && match_dist≠0 && match_dist≤MAX_DIST && match_dist≤rd_ptr.
  - cmp_bytes[i] = byte[rd-match_dist+i] for i<match_dist, else cur_bytes[i-match_dist] (overlap replication).
  - All zero when cmp_valid=0.
- Consume handshake:
  - adv_valid is ignored unless cur_valid.
  - adv_len=0 is treated as 1; adv_len is clamped to min(avail, CMP_BYTES).
  - rd_ptr += clamped length at the clock edge.
  - Outputs reflect the new rd_ptr in the next cycle (1-cycle latency).
- A simultaneous write and advance in the same cycle both take effect; avail updates by their net difference.
- FSM:
  - IDLE → FILL on first accepted beat, or → DRAIN if that beat has in_last.
  - FILL → RUN when avail≥CMP_BYTES; → DRAIN on accepted in_last.
  - RUN → DRAIN on accepted in_last.
  - DRAIN: in_ready=0; → DONE when avail==0 after the update.
  - DONE: done=1, in_ready=0, adv ignored; restart → IDLE with wr_ptr=rd_ptr=0.
  - restart in any other state is ignored.
- Reset mid-operation: immediate return to IDLE state and values; no partial outputs held.

Decomposition:
- comp_pkg holds:
  - byte_t;
  - the comp_win_state_e enum (IDLE, FILL, RUN, DRAIN, DONE);
  - default constants HIST_DEPTH, MAX_DIST, CMP_BYTES, IN_BYTES;
  - function to compute index width.
- One sub-module, comp_hist_ram:
  - circular byte store with an IN_BYTES-wide masked write;
  - two CMP_BYTES-wide unaligned combinational read ports (lookahead and match).
- FSM, pointers and overlap muxing live in comp_history_window.

Test Plan:
- Reset, then 2 full beats of bytes 0x01..0x20 → after 2 cycles avail=32, state RUN, cur_bytes=0x01..0x10, hash_key=0x010203, byte_ptr=0.
- Consume adv_len=4, then match_dist=4 → byte_ptr=4, cmp_valid=1, cmp_bytes=0x01..0x10.
- Overlap: stream "AB" repeated, rd_ptr=2, match_dist=2 → cmp_bytes="ABAB..." over all 16 bytes; match_dist=0 or >rd_ptr → cmp_valid=0, cmp_bytes=0.
- Back-pressure: consume nothing, write until in_ready=0 → avail equals largest value ≤ 4097 reachable in 16-byte steps (4096); beat with in_valid held is not written.
- Final partial beat in_nbytes=5, in_last=1 → DRAIN, cur_mask=0x001F at tail; after consuming all, done=1 and in_ready=0; restart → IDLE, byte_ptr=0.
- Assert reset mid-RUN with adv_valid high → outputs 0 and in_ready=1 immediately (async), no pointer update.
